fp_op_arbiter: RTL and testbench
================================

# fp_op_arbiter

Round-robin arbiter and sequencer that shares one non-pipelined FP operator (`fp_adder` or `fp_multiplier`) among `N_REQ` requesters. Requesters are typically CEU stage FSMs. The block latches the winning requester's operands, issues a one-cycle `valid` pulse to the operator, waits for `finish`, and routes the result back to the owning requester with a one-cycle completion pulse. It sits between the CEU controllers and a single shared operator instance, replacing per-stage dedicated operators where area matters.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `DBL_WIDTH`, 64: operand/result width.
- `TIMEOUT_CYCLES`, 64: WAIT-state watchdog limit. Used only when `FP_ARB_TIMEOUT_EN` is defined.

- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  N_REQ  per-requester request. Level; held until accepted.
- `req_a`, `req_b`  in  N_REQ*DBL_WIDTH  packed operands; slice i belongs to requester i. Stable while `req_valid[i]` is high.
- `req_ready`  out  N_REQ  one-hot accept. Combinational: high for the granted requester only while in IDLE.
- `resp_finish`  out  N_REQ  one-hot, one-cycle completion pulse.
- `resp_result`  out  DBL_WIDTH  result. Valid when any `resp_finish` is high; held until the next completion.
- `resp_err`  out  1  timeout flag. Qualified by `resp_finish`.
- `busy`  out  1  high in any state other than IDLE.
- `grant_id`  out  $clog2(N_REQ)  index of the current or last owner.
- `op_valid`  out  1  one-cycle issue pulse to the operator.
- `op_a`, `op_b`  out  DBL_WIDTH  latched operands; stable from ISSUE until return to IDLE.
- `op_ready`  in  1  operator ready.
- `op_finish`  in  1  operator completion pulse.
- `op_result`  in  DBL_WIDTH  operator result, sampled when `op_finish` is high.

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - Winner = first `req_valid` bit found scanning from `rr_ptr` upward, modulo `N_REQ`.
  - `req_ready[winner]` is high in the same cycle.
  - At the clock edge: latch `op_a`/`op_b` from the winner's slices, set `grant_id` to the winner, go to ISSUE.
  - No requests: stay in IDLE, `req_ready` = 0.
- ISSUE:
  - If `op_ready`: `op_valid` <= 1 for one cycle, go to WAIT.
  - Otherwise hold in ISSUE.
  - `op_finish` seen in ISSUE is ignored.
- WAIT:
  - On `op_finish`: `resp_result` <= `op_result`, `resp_finish[grant_id]` <= 1 for one cycle, `resp_err` <= 0.
  - Same edge: `rr_ptr` <= (`grant_id`+1) mod `N_REQ`, go to IDLE.
- Fairness:
  - A requester that was just served has lowest priority in the next arbitration.
  - Worst-case wait is (`N_REQ`−1) full operations.
- New `req_valid` edges during ISSUE or WAIT are not accepted. They are arbitrated on return to IDLE.
- Stray `op_finish` in IDLE or ISSUE is ignored; no response is generated.
- Reset in mid-operation aborts the operation. No `resp_finish` is produced. The shared operator must be reset by the same `rst`.

## Timing
- Reset values:
  - state = IDLE
  - `rr_ptr` = 0, `grant_id` = 0
  - `op_valid` = 0, `op_a` = `op_b` = 0
  - `resp_finish` = 0, `resp_result` = 0, `resp_err` = 0
  - `busy` = 0
  - `req_ready` = 0 while `rst` is high
- Accept at edge k, with `op_ready` high:
  - ISSUE during cycle k+1.
  - `op_valid` high during cycle k+2.
  - Operator finish at cycle f ≥ k+3 gives `resp_finish` high during cycle f+1.
- Back-to-back: the next accept can occur in cycle f+1, the same cycle as `resp_finish`.
- Single-requester throughput: one operation per (operator latency + 3) cycles.

## Configuration
- `FP_ARB_TIMEOUT_EN` defined:
  - A counter clears on entering WAIT and increments every WAIT cycle.
  - At `TIMEOUT_CYCLES` without `op_finish`: `resp_finish[grant_id]` pulses with `resp_err` = 1 and `resp_result` = 0. `rr_ptr` advances and the state goes to IDLE.
  - A later stray `op_finish` is ignored per the rules above.
- `FP_ARB_TIMEOUT_EN` undefined:
  - No counter is built, and `resp_err` is constant 0.
  - WAIT waits indefinitely for `op_finish`.

## Test plan
- Single request: req 2 with a = 1.5, b = 2.25 (adder model, 4-cycle latency) → `op_a`/`op_b` match, exactly one `op_valid` pulse, `resp_finish` = 4'b0100 with `resp_result` = 3.75, `busy` low afterwards.
- All four requesters asserted from reset → grants in order 0, 1, 2, 3, one `resp_finish` each, each result matching its own operands.
- `op_ready` low for 10 cycles while in ISSUE → `op_valid` delayed until `op_ready` rises, then a single pulse; the result is still correct.
- Req 1 and req 3 continuously valid, `rr_ptr` = 2 → grants alternate 3, 1, 3, 1; neither requester is starved.
- Assert `rst` for 1 cycle during WAIT → all outputs return to reset values, no `resp_finish`; a fresh request afterwards completes normally.
- With `FP_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 8, operator never finishes → `resp_finish` pulse with `resp_err` = 1 eight cycles after entering WAIT. A stray `op_finish` injected in IDLE afterwards produces no response.

Source files
------------

// File: rtl/fp_op_arbiter.sv
// Round-robin arbiter/sequencer sharing one non-pipelined FP operator among N_REQ requesters.
// Optional WAIT-state watchdog is built only when FP_ARB_TIMEOUT_EN is defined.
module fp_op_arbiter #(
    parameter int  N_REQ          = 4,
    parameter int  DBL_WIDTH      = 64,
    parameter int  TIMEOUT_CYCLES = 64,
    localparam int ID_W           = $clog2(N_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*DBL_WIDTH-1:0] req_a,
    input  logic [N_REQ*DBL_WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]           req_ready,
    output logic [N_REQ-1:0]           resp_finish,
    output logic [DBL_WIDTH-1:0]       resp_result,
    output logic                       resp_err,
    output logic                       busy,
    output logic [ID_W-1:0]            grant_id,
    output logic                       op_valid,
    output logic [DBL_WIDTH-1:0]       op_a,
    output logic [DBL_WIDTH-1:0]       op_b,
    input  logic                       op_ready,
    input  logic                       op_finish,
    input  logic [DBL_WIDTH-1:0]       op_result
);

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
        $error("fp_op_arbiter: N_REQ must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_tmo
        $error("fp_op_arbiter: TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

    state_t                 state;
    logic [ID_W-1:0]        rr_ptr;
    logic [ID_W-1:0]        win_idx;
    logic [ID_W-1:0]        next_ptr;
    logic                   win_found;
    logic [N_REQ-1:0]       rot_valid;
    logic [DBL_WIDTH-1:0]   win_a;
    logic [DBL_WIDTH-1:0]   win_b;
    int                     scan_idx;

`ifdef FP_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_cnt;
`else
    assign resp_err = 1'b0;
`endif

    function automatic logic [N_REQ-1:0] id_onehot(input logic [ID_W-1:0] id);
        logic [N_REQ-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

    // Rotate so bit 0 is the requester at rr_ptr; the first set bit is the winner.
    always_comb begin
        rot_valid = N_REQ'({req_valid, req_valid} >> rr_ptr);
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!win_found && rot_valid[k]) begin
                win_found = 1'b1;
                scan_idx  = int'(rr_ptr) + k;
                if (scan_idx >= N_REQ) begin
                    scan_idx = scan_idx - N_REQ;
                end
                win_idx = ID_W'(scan_idx);
            end
        end
    end

    always_comb begin
        win_a = '0;
        win_b = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (win_idx == ID_W'(k)) begin
                win_a = req_a[k*DBL_WIDTH +: DBL_WIDTH];
                win_b = req_b[k*DBL_WIDTH +: DBL_WIDTH];
            end
        end
    end

    assign req_ready = (state == ST_IDLE && win_found && !rst) ? id_onehot(win_idx) : '0;
    assign busy      = (state != ST_IDLE);
    assign next_ptr  = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            grant_id    <= '0;
            op_valid    <= 1'b0;
            op_a        <= '0;
            op_b        <= '0;
            resp_finish <= '0;
            resp_result <= '0;
`ifdef FP_ARB_TIMEOUT_EN
            resp_err    <= 1'b0;
            tmo_cnt     <= '0;
`endif
        end else begin
            op_valid    <= 1'b0;
            resp_finish <= '0;
            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        op_a     <= win_a;
                        op_b     <= win_b;
                        grant_id <= win_idx;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (op_ready) begin
                        op_valid <= 1'b1;
                        state    <= ST_WAIT;
`ifdef FP_ARB_TIMEOUT_EN
                        tmo_cnt  <= '0;
`endif
                    end
                end
                ST_WAIT: begin
                    if (op_finish) begin
                        resp_result <= op_result;
                        resp_finish <= id_onehot(grant_id);
                        rr_ptr      <= next_ptr;
                        state       <= ST_IDLE;
`ifdef FP_ARB_TIMEOUT_EN
                        resp_err    <= 1'b0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        // Watchdog expiry: complete the owner with an error and a zero result.
                        resp_result <= '0;
                        resp_finish <= id_onehot(grant_id);
                        resp_err    <= 1'b1;
                        rr_ptr      <= next_ptr;
                        state       <= ST_IDLE;
                    end else begin
                        tmo_cnt     <= tmo_cnt + 1'b1;
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_op_arbiter.sv
// Self-checking bench for fp_op_arbiter: adder model, queue scoreboard for issues and responses.
module tb_fp_op_arbiter;

    localparam int N      = 4;
    localparam int W      = 64;
    localparam int TMO    = 8;
    localparam int OP_LAT = 4;
    localparam int BUDGET = 400;

    typedef struct {
        int          id;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic        err;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   resp_finish;
    logic [W-1:0]   resp_result;
    logic           resp_err;
    logic           busy;
    logic [1:0]     grant_id;
    logic           op_valid;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic           op_ready;
    logic           op_finish;
    logic [W-1:0]   op_result;

    logic           m_fin;
    logic [W-1:0]   m_res;
    int             m_cnt;
    logic           op_hang;
    logic           stray_fin;

    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   n_valid  = 0;
    int   t_acc    = 0;
    int   t_valid  = 0;
    int   t_fin    = 0;
    int   t_resp   = 0;
    int   want[N]  = '{default: 0};
    int   done[N]  = '{default: 0};
    int   exp_seq[N] = '{default: 0};
    logic [N-1:0] acc = '0;
    exp_t iss_q[$];
    exp_t resp_q[$];
    exp_t mon_e;

    fp_op_arbiter #(
        .N_REQ(N),
        .DBL_WIDTH(W),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_a(req_a),
        .req_b(req_b),
        .req_ready(req_ready),
        .resp_finish(resp_finish),
        .resp_result(resp_result),
        .resp_err(resp_err),
        .busy(busy),
        .grant_id(grant_id),
        .op_valid(op_valid),
        .op_a(op_a),
        .op_b(op_b),
        .op_ready(op_ready),
        .op_finish(op_finish),
        .op_result(op_result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Operands per requester and sequence number; sequences 0 and 1 coincide.
    function automatic real opa(input int i, input int s);
        return 0.5 + 0.5 * i + 0.125 * (s * (s - 1));
    endfunction
    function automatic real opb(input int i, input int s);
        return 1.75 + 0.25 * i + 0.0625 * (s * (s - 1));
    endfunction

    task automatic expect_op(input int id);
        exp_t e;
        real  a, b;
        a     = opa(id, exp_seq[id]);
        b     = opb(id, exp_seq[id]);
        e.id  = id;
        e.a   = $realtobits(a);
        e.b   = $realtobits(b);
        e.res = $realtobits(a + b);
        e.err = 1'b0;
        exp_seq[id]++;
        iss_q.push_back(e);
        resp_q.push_back(e);
    endtask

    task automatic expect_tmo(input int id);
        exp_t e;
        e.id  = id;
        e.a   = $realtobits(opa(id, exp_seq[id]));
        e.b   = $realtobits(opb(id, exp_seq[id]));
        e.res = '0;
        e.err = 1'b1;
        exp_seq[id]++;
        iss_q.push_back(e);
        resp_q.push_back(e);
    endtask

    // Non-pipelined adder model with fixed latency; reset by the same rst.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt <= 0;
            m_fin <= 1'b0;
            m_res <= '0;
        end else begin
            m_fin <= 1'b0;
            if (op_valid) begin
                m_res <= $realtobits($bitstoreal(op_a) + $bitstoreal(op_b));
                m_cnt <= OP_LAT;
            end else if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1 && !op_hang) m_fin <= 1'b1;
            end
        end
    end
    assign op_finish = m_fin | stray_fin;
    assign op_result = m_res;

    // Requesters: hold valid while accepted count is below requested count.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) done[i]++;
            req_valid[i] = (done[i] < want[i]);
            req_a[i*W +: W] = $realtobits(opa(i, done[i]));
            req_b[i*W +: W] = $realtobits(opb(i, done[i]));
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            acc = '0;
        end else begin
            acc = req_ready & req_valid;
            if (|acc) t_acc = cyc;
            if (op_finish) t_fin = cyc;
            if (op_valid) begin
                n_valid++;
                t_valid = cyc;
                if (iss_q.size() == 0) begin
                    check("op_valid_spurious", op_valid, 1'b0);
                end else begin
                    mon_e = iss_q.pop_front();
                    check("op_a", op_a, mon_e.a);
                    check("op_b", op_b, mon_e.b);
                    check("grant_id", grant_id, mon_e.id);
                end
            end
            if (resp_finish != '0) begin
                t_resp = cyc;
                if (resp_q.size() == 0) begin
                    check("resp_spurious", resp_finish, '0);
                end else begin
                    mon_e = resp_q.pop_front();
                    check("resp_finish", resp_finish, 64'(1) << mon_e.id);
                    check("resp_result", resp_result, mon_e.res);
                    check("resp_err", resp_err, mon_e.err);
                end
            end
        end
    end

    task automatic drain(input string tag);
        int n = 0;
        while ((resp_q.size() != 0 || iss_q.size() != 0 || busy || req_valid != '0) && n < BUDGET) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        check(tag, n < BUDGET, 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic wait_issue(input string tag);
        int n = 0;
        int v = n_valid;
        while (n_valid == v && n < BUDGET) begin
            @(posedge clk);
            n++;
        end
        check(tag, n < BUDGET, 1'b1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_op_valid"}, op_valid, 1'b0);
        check({tag, "_op_a"}, op_a, '0);
        check({tag, "_op_b"}, op_b, '0);
        check({tag, "_resp_finish"}, resp_finish, '0);
        check({tag, "_resp_result"}, resp_result, '0);
        check({tag, "_resp_err"}, resp_err, 1'b0);
        check({tag, "_grant_id"}, grant_id, '0);
        check({tag, "_req_ready"}, req_ready, '0);
    endtask

    initial begin
        int v0;
        rst       = 1'b1;
        op_ready  = 1'b1;
        op_hang   = 1'b0;
        stray_fin = 1'b0;

        // All four requesters raised during reset: served 0,1,2,3.
        for (int i = 0; i < N; i++) begin
            want[i] = 1;
            expect_op(i);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_valid_seen", req_valid, 4'b1111);
        check_reset_vals("rst");
        @(posedge clk);
        #1 rst = 1'b0;
        drain("all4");

        // Single request from requester 2: 1.5 + 2.25.
        v0 = n_valid;
        want[2]++;
        expect_op(2);
        drain("single");
        check("single_valid_pulses", n_valid - v0, 1);
        check("single_result", resp_result, $realtobits(3.75));
        check("single_op_a", op_a, $realtobits(1.5));
        check("single_acc_to_valid", t_valid - t_acc, 2);
        check("single_fin_to_resp", t_resp - t_fin, 1);
        repeat (3) @(negedge clk);
        check("single_result_held", resp_result, $realtobits(3.75));

        // Operator not ready for 10 cycles in ISSUE, with a stray finish there.
        op_ready = 1'b0;
        v0 = n_valid;
        want[0]++;
        expect_op(0);
        repeat (3) @(posedge clk);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1 stray_fin = (c == 4);
        end
        #1 stray_fin = 1'b0;
        @(negedge clk);
        check("stall_no_valid", n_valid - v0, 0);
        check("stall_busy", busy, 1'b1);
        @(posedge clk);
        #1 op_ready = 1'b1;
        drain("stall");
        check("stall_valid_pulses", n_valid - v0, 1);

        // Prime rr_ptr to 2 via requester 1, then 1 and 3 contend: 3,1,3,1.
        want[1]++;
        expect_op(1);
        drain("prime");
        expect_op(3);
        expect_op(1);
        expect_op(3);
        expect_op(1);
        want[1] += 2;
        want[3] += 2;
        drain("rr_alt");

        // Reset during WAIT aborts with no response.
        want[0]++;
        expect_op(0);
        wait_issue("abort_issue");
        @(posedge clk);
        #1 rst = 1'b1;
        resp_q.delete();
        #1 check_reset_vals("abort");
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_idle", busy, 1'b0);
        want[2]++;
        expect_op(2);
        drain("after_abort");

        // Stray finish while idle produces nothing.
        @(posedge clk);
        #1 stray_fin = 1'b1;
        @(posedge clk);
        #1 stray_fin = 1'b0;
        @(negedge clk);
        check("stray_idle_finish", resp_finish, '0);
        check("stray_idle_busy", busy, 1'b0);

`ifdef FP_ARB_TIMEOUT_EN
        op_hang = 1'b1;
        want[1]++;
        expect_tmo(1);
        drain("timeout");
        check("timeout_latency", t_resp - t_valid, TMO);
        op_hang = 1'b0;
        @(posedge clk);
        #1 stray_fin = 1'b1;
        @(posedge clk);
        #1 stray_fin = 1'b0;
        repeat (2) @(negedge clk);
        check("tmo_stray_finish", resp_finish, '0);
        check("tmo_stray_busy", busy, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
